// File: rtl/uart_irq_ctrl.sv
// 16550-style interrupt controller: pending latches, priority resolution, registered IIR/IRQ.
// Define UART_IRQ_TIMEOUT_EN to include the RX character-timeout counter.
module uart_irq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ier_i,
    input  logic       fifo_en_i,
    input  logic [1:0] rx_trig_i,
    input  logic [1:0] wls_i,
    input  logic [4:0] rx_count_i,
    input  logic       rx_push_i,
    input  logic       rx_pop_i,
    input  logic       baud_pulse_i,
    input  logic       rx_err_i,
    input  logic       lsr_rd_i,
    input  logic       tx_empty_i,
    input  logic       thr_wr_i,
    input  logic       iir_rd_i,
    input  logic       msr_delta_i,
    input  logic       msr_rd_i,
    output logic       irq_o,
    output logic [3:0] iir_o,
    output logic       timeout_o
);

    typedef enum logic [3:0] {
        IIR_MODEM = 4'b0000,
        IIR_NONE  = 4'b0001,
        IIR_THRE  = 4'b0010,
        IIR_RDA   = 4'b0100,
        IIR_RLS   = 4'b0110,
        IIR_TO    = 4'b1100
    } iir_code_t;

    logic       rls_p, thre_p, msr_p, to_p;
    logic       tx_empty_q, etbei_q;
    logic [4:0] trig_lvl;
    logic       rda, thre_set, thre_clr;
    iir_code_t  iir_nxt;

    always_comb begin
        trig_lvl = 5'd1;
        case (rx_trig_i)
            2'b00: trig_lvl = 5'd1;
            2'b01: trig_lvl = 5'd4;
            2'b10: trig_lvl = 5'd8;
            2'b11: trig_lvl = 5'd14;
            default: trig_lvl = 5'd1;
        endcase
    end

    assign rda = fifo_en_i ? (rx_count_i >= trig_lvl) : (rx_count_i != '0);

    // THRE rises on TX going empty, or on ETBEI being enabled while already empty
    assign thre_set = tx_empty_i & (~tx_empty_q | (ier_i[1] & ~etbei_q));
    assign thre_clr = thr_wr_i | (iir_rd_i & (iir_o == IIR_THRE));

`ifdef UART_IRQ_TIMEOUT_EN
    logic [9:0] to_cnt, to_cnt_nxt, to_limit;
    logic       cnt_clr, to_clr;

    always_comb begin
        case (wls_i)
            2'b00:   to_limit = 10'd448;
            2'b01:   to_limit = 10'd512;
            2'b10:   to_limit = 10'd576;
            default: to_limit = 10'd640;
        endcase
        to_clr  = rx_push_i | rx_pop_i | (rx_count_i == '0);
        cnt_clr = to_clr | ~fifo_en_i;
        to_cnt_nxt = to_cnt;
        if (cnt_clr)
            to_cnt_nxt = '0;
        else if (baud_pulse_i && (to_cnt < to_limit))
            to_cnt_nxt = to_cnt + 10'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            to_p   <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            if (!cnt_clr && (to_cnt_nxt >= to_limit))
                to_p <= 1'b1;
            else if (to_clr)
                to_p <= 1'b0;
        end
    end
`else
    logic unused_to;
    assign unused_to = ^{baud_pulse_i, rx_push_i, rx_pop_i, wls_i};
    assign to_p      = 1'b0;
`endif

    assign timeout_o = to_p;

    always_comb begin
        iir_nxt = IIR_NONE;
        if (ier_i[2] & rls_p)
            iir_nxt = IIR_RLS;
        else if (ier_i[0] & rda)
            iir_nxt = IIR_RDA;
        else if (ier_i[0] & to_p)
            iir_nxt = IIR_TO;
        else if (ier_i[1] & thre_p)
            iir_nxt = IIR_THRE;
        else if (ier_i[3] & msr_p)
            iir_nxt = IIR_MODEM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rls_p      <= 1'b0;
            thre_p     <= 1'b0;
            msr_p      <= 1'b0;
            tx_empty_q <= 1'b1;
            etbei_q    <= 1'b0;
            iir_o      <= IIR_NONE;
            irq_o      <= 1'b0;
        end else begin
            rls_p      <= rx_err_i | (rls_p & ~lsr_rd_i);
            msr_p      <= msr_delta_i | (msr_p & ~msr_rd_i);
            thre_p     <= thre_set | (thre_p & ~thre_clr);
            tx_empty_q <= tx_empty_i;
            etbei_q    <= ier_i[1];
            iir_o      <= iir_nxt;
            irq_o      <= ~iir_nxt[0];
        end
    end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Self-checking bench for uart_irq_ctrl; expectations queued at stimulus, popped at observation.
// Follows UART_IRQ_TIMEOUT_EN the same way the design does.
module tb_uart_irq_ctrl;

`ifdef UART_IRQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ier_i = '0;
    logic       fifo_en_i = 1'b0;
    logic [1:0] rx_trig_i = '0;
    logic [1:0] wls_i = '0;
    logic [4:0] rx_count_i = '0;
    logic       rx_push_i = 1'b0, rx_pop_i = 1'b0, baud_pulse_i = 1'b0;
    logic       rx_err_i = 1'b0, lsr_rd_i = 1'b0, tx_empty_i = 1'b0, thr_wr_i = 1'b0;
    logic       iir_rd_i = 1'b0, msr_delta_i = 1'b0, msr_rd_i = 1'b0;
    logic       irq_o, timeout_o;
    logic [3:0] iir_o;

    typedef struct {
        string      name;
        logic [5:0] val;   // {irq, iir[3:0], timeout}
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_irq_ctrl dut (
        .clk(clk), .rst(rst), .ier_i(ier_i), .fifo_en_i(fifo_en_i),
        .rx_trig_i(rx_trig_i), .wls_i(wls_i), .rx_count_i(rx_count_i),
        .rx_push_i(rx_push_i), .rx_pop_i(rx_pop_i), .baud_pulse_i(baud_pulse_i),
        .rx_err_i(rx_err_i), .lsr_rd_i(lsr_rd_i), .tx_empty_i(tx_empty_i),
        .thr_wr_i(thr_wr_i), .iir_rd_i(iir_rd_i), .msr_delta_i(msr_delta_i),
        .msr_rd_i(msr_rd_i), .irq_o(irq_o), .iir_o(iir_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ex(input logic [3:0] iir, input logic to);
        return {~iir[0], iir, to};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_err_i = 1'b1; msr_delta_i = 1'b1; ier_i = 4'b1111;
        exp_q.push_back('{"reset_state", ex(4'b0001, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        rx_err_i = 1'b0; msr_delta_i = 1'b0; ier_i = '0;
        rst = 1'b0;
        exp_q.push_back('{"idle_after_reset", ex(4'b0001, 1'b0)});
        step(); step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
    endtask

    task automatic test_rda();
        logic [4:0] cnt_tab [6] = '{5'd3, 5'd4, 5'd13, 5'd14, 5'd1, 5'd0};
        logic [1:0] trg_tab [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
        logic       fen_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] iir_tab [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0100, 4'b0001};
        ier_i = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            fifo_en_i = fen_tab[i]; rx_trig_i = trg_tab[i]; rx_count_i = cnt_tab[i];
            exp_q.push_back('{$sformatf("rda_%0d", i), ex(iir_tab[i], 1'b0)});
            step();
            e = exp_q.pop_front(); n_checks++;
            if ({irq_o, iir_o, timeout_o} !== e.val) begin
                n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
            end
        end
    endtask

    task automatic test_timeout();
        ier_i = 4'b0001; fifo_en_i = 1'b1; rx_trig_i = 2'b01; wls_i = 2'b11; rx_count_i = '0;
        step();
        rx_count_i = 5'd2; baud_pulse_i = 1'b1;
        repeat (639) step();
        exp_q.push_back('{"timeout_639", ex(4'b0001, 1'b0)});
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        exp_q.push_back('{"timeout_640", ex(4'b0001, TO_EN)});
        exp_q.push_back('{"timeout_iir", ex(TO_EN ? 4'b1100 : 4'b0001, TO_EN)});
        step();
        baud_pulse_i = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        rx_pop_i = 1'b1;
        exp_q.push_back('{"timeout_pop", ex(TO_EN ? 4'b1100 : 4'b0001, 1'b0)});
        exp_q.push_back('{"timeout_pop_iir", ex(4'b0001, 1'b0)});
        step();
        rx_pop_i = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
    endtask

    task automatic test_thre();
        ier_i = 4'b0010; rx_count_i = '0; tx_empty_i = 1'b0;
        step();
        tx_empty_i = 1'b1;
        exp_q.push_back('{"thre_latency", ex(4'b0001, 1'b0)});
        exp_q.push_back('{"thre_set", ex(4'b0010, 1'b0)});
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front(); n_checks++;
            if ({irq_o, iir_o, timeout_o} !== e.val) begin
                n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
            end
        end
        iir_rd_i = 1'b1;
        exp_q.push_back('{"thre_iir_rd_lag", ex(4'b0010, 1'b0)});
        exp_q.push_back('{"thre_iir_rd_clr", ex(4'b0001, 1'b0)});
        for (int i = 0; i < 2; i++) begin
            step();
            iir_rd_i = 1'b0;
            e = exp_q.pop_front(); n_checks++;
            if ({irq_o, iir_o, timeout_o} !== e.val) begin
                n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
            end
        end
        thr_wr_i = 1'b1;
        step();
        thr_wr_i = 1'b0;
        exp_q.push_back('{"thr_wr_no_new_thre", ex(4'b0001, 1'b0)});
        step(); step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        ier_i = 4'b0000;
        step();
        ier_i = 4'b0010;
        exp_q.push_back('{"thre_on_etbei_rise", ex(4'b0010, 1'b0)});
        step(); step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        thr_wr_i = 1'b1;
        step();
        thr_wr_i = 1'b0;
        exp_q.push_back('{"thre_thr_wr_clr", ex(4'b0001, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
    endtask

    task automatic test_priority();
        ier_i = 4'b1111; fifo_en_i = 1'b1; rx_trig_i = 2'b01; rx_count_i = 5'd5;
        rx_err_i = 1'b1; lsr_rd_i = 1'b1; msr_delta_i = 1'b1;
        step();
        rx_err_i = 1'b0; lsr_rd_i = 1'b0; msr_delta_i = 1'b0;
        exp_q.push_back('{"prio_rls_set_wins", ex(4'b0110, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        lsr_rd_i = 1'b1;
        step();
        lsr_rd_i = 1'b0;
        exp_q.push_back('{"prio_rda_after_lsr", ex(4'b0100, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        rx_count_i = 5'd3;
        exp_q.push_back('{"prio_modem_after_drain", ex(4'b0000, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        ier_i = 4'b0111;
        exp_q.push_back('{"msr_masked", ex(4'b0001, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        ier_i = 4'b1111;
        exp_q.push_back('{"msr_latch_kept", ex(4'b0000, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        msr_rd_i = 1'b1;
        step();
        msr_rd_i = 1'b0;
        exp_q.push_back('{"prio_none_after_msr_rd", ex(4'b0001, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
    endtask

    task automatic test_reset_mid_count();
        ier_i = 4'b0101; fifo_en_i = 1'b1; rx_trig_i = 2'b01; wls_i = 2'b11;
        rx_count_i = 5'd2; baud_pulse_i = 1'b1;
        repeat (100) step();
        rx_err_i = 1'b1;
        step();
        rx_err_i = 1'b0;
        exp_q.push_back('{"pre_reset_rls", ex(4'b0110, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        #3 rst = 1'b1;
        exp_q.push_back('{"reset_immediate", ex(4'b0001, 1'b0)});
        #1;
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        ier_i = 4'b0001;
        step();
        rst = 1'b0;
        repeat (639) step();
        exp_q.push_back('{"count_abandoned", ex(4'b0001, 1'b0)});
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        exp_q.push_back('{"count_restarted", ex(4'b0001, TO_EN)});
        step();
        baud_pulse_i = 1'b0; rx_pop_i = 1'b1;
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
        step();
        rx_pop_i = 1'b0; rx_count_i = '0;
        step();
    endtask

    task automatic test_first_cycle_event();
        ier_i = 4'b0100; tx_empty_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0; rx_err_i = 1'b1;
        step();
        rx_err_i = 1'b0;
        exp_q.push_back('{"event_after_reset", ex(4'b0110, 1'b0)});
        step();
        e = exp_q.pop_front(); n_checks++;
        if ({irq_o, iir_o, timeout_o} !== e.val) begin
            n_errors++; $display("FAIL %s: got %b expected %b", e.name, {irq_o, iir_o, timeout_o}, e.val);
        end
    endtask

    initial begin
        test_reset();
        test_rda();
        test_timeout();
        test_thre();
        test_priority();
        test_reset_mid_count();
        test_first_cycle_event();
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_irq_ctrl.md
UART_IRQ_CTRL -- requirements
Module: uart_irq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have inputs: ier_i  in  4  enables {EDSSI, ELSI, ETBEI, ERBFI} as bits [3:0]; fifo_en_i  in  1  FCR FIFO enable; rx_trig_i  in  2  RX trigger select; wls_i  in  2  word length select.
REQ-004 SHALL have inputs: rx_count_i  in  5  RX FIFO occupancy 0..16; rx_push_i  in  1  RX FIFO write pulse; rx_pop_i  in  1  RX FIFO read pulse; baud_pulse_i  in  1  16x baud tick.
REQ-005 SHALL have inputs: rx_err_i  in  1  OE/PE/FE/BI event pulse; lsr_rd_i  in  1  LSR read pulse; tx_empty_i  in  1  TX FIFO empty level; thr_wr_i  in  1  THR write pulse; iir_rd_i  in  1  IIR read pulse; msr_delta_i  in  1  modem delta pulse; msr_rd_i  in  1  MSR read pulse.
REQ-006 SHALL have outputs: irq_o  out  1  interrupt request; iir_o  out  4  IIR[3:0]; timeout_o  out  1  character-timeout pending.

Function
REQ-007 SHALL hold four pending latches: rls_p, thre_p, msr_p, to_p (timeout); RDA is a level derived from rx_count_i.
REQ-008 rls_p SHALL set on rx_err_i and clear on lsr_rd_i; same cycle set wins.
REQ-009 msr_p SHALL set on msr_delta_i and clear on msr_rd_i; same cycle set wins.
REQ-010 thre_p SHALL set on tx_empty_i 0->1 transition or on ier_i[1] 0->1 while tx_empty_i=1; SHALL clear on thr_wr_i, or on iir_rd_i while iir_o=0010; set wins over clear.
REQ-011 RDA SHALL be true when fifo_en_i=1 and rx_count_i >= trigger (00->1, 01->4, 10->8, 11->14), or when fifo_en_i=0 and rx_count_i >= 1.
REQ-012 10-bit timeout counter SHALL clear on rx_push_i, rx_pop_i, rx_count_i=0 or fifo_en_i=0; otherwise SHALL increment on baud_pulse_i, saturating at limit.
REQ-013 limit SHALL be 64*(7+wls_i): 448, 512, 576, 640 ticks (four character times).
REQ-014 to_p SHALL set the cycle the counter reaches limit; SHALL clear on rx_push_i, rx_pop_i or rx_count_i=0.
REQ-015 priority SHALL be: RLS (ier[2]&rls_p) > RDA (ier[0]&RDA) > timeout (ier[0]&to_p) > THRE (ier[1]&thre_p) > modem (ier[3]&msr_p).
REQ-016 iir_o SHALL encode 0110 RLS, 0100 RDA, 1100 timeout, 0010 THRE, 0000 modem, 0001 none.
REQ-017 iir_o and irq_o SHALL be registered, reflecting latch state with one-cycle latency; irq_o = ~iir_o[0].
REQ-018 disabling an ier_i bit SHALL mask its source on the next cycle without clearing its latch.
REQ-019 timeout_o SHALL equal to_p regardless of ier_i.

Reset
REQ-020 on rst: all latches 0, counter 0, iir_o=0001, irq_o=0, timeout_o=0, previous-sample registers for tx_empty_i and ier_i[1] = 1 and 0 respectively.
REQ-021 reset mid-count SHALL abandon the count; no event within the first cycle after rst release SHALL be lost.

Configuration
REQ-022 macro UART_IRQ_TIMEOUT_EN defined: counter and to_p present as in REQ-012..014.
REQ-023 macro undefined: counter and to_p removed, timeout_o tied 0, code 1100 never produced; all other priorities unchanged.

Verification
REQ-024 ier=0001, fifo_en=1, rx_trig=01, rx_count 3->4 -> iir_o=0100, irq_o=1 one cycle after count reaches 4.
REQ-025 ier=0001, fifo_en=1, wls=11, rx_count=2, no push/pop, 640 baud pulses -> timeout_o=1, iir_o=1100; one rx_pop_i -> timeout_o=0 next cycle.
REQ-026 ier=0010, tx_empty 0->1 -> iir_o=0010; iir_rd_i -> iir_o=0001 next-but-one cycle; thr_wr_i with tx_empty high -> no new THRE.
REQ-027 ier=1111, rls_p, RDA and msr_p all pending -> iir_o=0110; lsr_rd_i -> 0100; drain below trigger -> 0000; msr_rd_i -> 0001.
REQ-028 rx_err_i and lsr_rd_i same cycle -> rls_p stays 1; rst asserted mid-timeout count -> all outputs to reset values immediately.
